frontend_cmd_arbiter: RTL
=========================

Name: frontend_cmd_arbiter

Overview:
- Shares the single backend command channel of one rank controller among NUM_REQ frontend requesters.
- Arbitration is round-robin.
- Issued commands go through a one-entry registered output stage.
- A requester-ID FIFO tracks outstanding reads, so each returning read-data beat is routed back to the requester that issued the read.
- Sits between the frontend request ports and the backend controller's command/read-data interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_W, `FRONTEND_CMD_BITS, frontend command width.
- DATA_W, `DQ_BITS*8, burst data width.
- MAX_RD, 8, max outstanding reads; tag FIFO depth, power of two.

Ports:
- clk  in  1  system clock.
- power_on_rst_n  in  1  async active-low reset.
- i_req_valid  in  NUM_REQ  per-requester command valid.
- i_req_command  in  NUM_REQ*CMD_W  packed frontend_command_t per requester; requester i occupies slice [i*CMD_W +: CMD_W].
- i_req_write_data  in  NUM_REQ*DATA_W  per-requester write data.
- o_req_ready  out  NUM_REQ  one-hot accept.
- o_cmd_valid  out  1  command valid to backend.
- o_cmd  out  CMD_W  granted command.
- o_write_data  out  DATA_W  granted write data.
- i_cmd_ready  in  1  backend controller ready.
- i_read_data  in  DATA_W  backend read data.
- i_read_data_valid  in  1  backend read data valid, single-cycle pulse per read.
- o_rsp_data  out  DATA_W  routed read data.
- o_rsp_valid  out  NUM_REQ  one-hot read-data valid.
- o_err_underflow  out  1  sticky error flag.

Behaviour:
- Clock and reset: single clock clk. power_on_rst_n is asynchronous, active-low.
- Reset values: o_cmd_valid=0, o_cmd=0, o_write_data=0, o_rsp_valid=0, o_rsp_data=0, o_err_underflow=0. RR pointer=0, tag FIFO empty. o_req_ready is combinational and therefore 0 while no slot is free.
- Reset mid-operation: clears everything; in-flight reads are forgotten.
- Slot free: !o_cmd_valid || i_cmd_ready (same-cycle refill allowed).
- Eligibility: requester i is eligible when i_req_valid[i] is set and, for a read (op_type==OP_READ), the tag FIFO is not full. Exception: a full FIFO counts as not full in a cycle with i_read_data_valid (simultaneous pop).
- Grant: first eligible requester starting at the RR pointer, wrapping modulo NUM_REQ.
  - o_req_ready[grant]=1 only if the slot is free. At most one bit is set.
- Accept (valid&ready on a requester):
  - Output stage loads the command and write data.
  - RR pointer becomes (grant+1) mod NUM_REQ.
  - A read pushes the grant index into the tag FIFO.
- Latency: request accepted in cycle N → o_cmd_valid in cycle N+1.
- Backend backpressure: o_cmd and o_write_data hold stable while o_cmd_valid && !i_cmd_ready.
- No eligible requester: pointer unchanged; o_cmd_valid drops after the current command is taken.
- Read return: on i_read_data_valid, pop the FIFO head h. Next cycle: o_rsp_valid[h]=1 for one cycle, o_rsp_data=i_read_data (registered, 1-cycle latency). There is no response backpressure.
- Underflow: i_read_data_valid with an empty FIFO (and no same-cycle push) → beat dropped, o_rsp_valid stays 0, o_err_underflow set until reset.
- Simultaneous push and pop: allowed at any occupancy, including full and empty.
  - Empty FIFO with a same-cycle push: pop returns the pushed ID; occupancy stays 0.
- Writes never touch the FIFO.
- Arithmetic: FIFO pointers are log2(MAX_RD)+1 bits and wrap naturally. Count range is 0..MAX_RD.

Optional Feature:
- Macro: FRONTEND_ARB_PERF_CNT_EN.
- Defined: adds output o_grant_cnt, NUM_REQ*16 bits, one counter per requester.
  - Counter i increments on each accepted command from requester i and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package (frontend_command_definition_pkg): frontend_command_t, OP_READ/OP_WRITE encodings, the arb_tag_t typedef (ID width = $clog2(NUM_REQ)) and the RR-next helper function.
- Sub-module rd_tag_fifo: sync FIFO of requester IDs, parameterised by depth and width, with push/pop/full/empty/count.

Test Plan:
- RR fairness: all 4 requesters hold valid writes, i_cmd_ready=1 → grants 0,1,2,3,0 on consecutive cycles; o_cmd_valid continuous from cycle 1.
- Backpressure: requester 2 issues a write, i_cmd_ready=0 for 5 cycles → o_cmd stable for 5 cycles; no further o_req_ready; accept proceeds on the 6th cycle.
- Read routing: reads from requesters 3,1,3 accepted, then three i_read_data_valid pulses with data A,B,C → o_rsp_valid = 4'b1000(A), 4'b0010(B), 4'b1000(C), each 1 cycle after its pulse.
- FIFO full: MAX_RD=8 reads outstanding; requester 0 read pending and requester 1 write pending → write granted, read stalled. Read granted in the same cycle that i_read_data_valid pops an entry.
- Underflow: i_read_data_valid with no outstanding reads → no o_rsp_valid; o_err_underflow=1 and remains set until power_on_rst_n is asserted.
- Reset mid-flight: 3 reads outstanding and o_cmd_valid=1, assert power_on_rst_n=0 → all outputs 0 asynchronously; after release the RR pointer starts at requester 0.

Source files
------------

// File: rtl/frontend_cmd_arbiter_pkg.sv
// Shared definitions for the frontend command arbiter: command layout,
// op encodings, requester tag type and round-robin helper.
// The command and data widths fall back to defaults when the surrounding
// build does not supply FRONTEND_CMD_BITS / DQ_BITS.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

package frontend_command_definition_pkg;

   localparam int ARB_NUM_REQ = 4;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_type_e;

   // The op type sits in the MSB so that it can be picked out of a packed slice.
   typedef struct packed {
      op_type_e                     op_type;
      logic [`FRONTEND_CMD_BITS-2:0] addr;
   } frontend_command_t;

   typedef logic [$clog2(ARB_NUM_REQ)-1:0] arb_tag_t;

   // Next round-robin start position after requester 'cur' won.
   function automatic int rr_next(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/frontend_cmd_arbiter_if.sv
// Frontend/backend signal bundle of the command arbiter.
// Optional feature macro: FRONTEND_ARB_PERF_CNT_EN adds o_grant_cnt.
interface frontend_cmd_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int CMD_W   = `FRONTEND_CMD_BITS,
   parameter int DATA_W  = `DQ_BITS*8
);
   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ*CMD_W-1:0]  i_req_command;
   logic [NUM_REQ*DATA_W-1:0] i_req_write_data;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic                      o_cmd_valid;
   logic [CMD_W-1:0]          o_cmd;
   logic [DATA_W-1:0]         o_write_data;
   logic                      i_cmd_ready;
   logic [DATA_W-1:0]         i_read_data;
   logic                      i_read_data_valid;
   logic [DATA_W-1:0]         o_rsp_data;
   logic [NUM_REQ-1:0]        o_rsp_valid;
   logic                      o_err_underflow;
`ifdef FRONTEND_ARB_PERF_CNT_EN
   logic [NUM_REQ*16-1:0]     o_grant_cnt;
`endif

   modport slave (
      input  i_req_valid, i_req_command, i_req_write_data,
             i_cmd_ready, i_read_data, i_read_data_valid,
      output o_req_ready, o_cmd_valid, o_cmd, o_write_data,
             o_rsp_data, o_rsp_valid, o_err_underflow
`ifdef FRONTEND_ARB_PERF_CNT_EN
      , output o_grant_cnt
`endif
   );

   modport master (
      output i_req_valid, i_req_command, i_req_write_data,
             i_cmd_ready, i_read_data, i_read_data_valid,
      input  o_req_ready, o_cmd_valid, o_cmd, o_write_data,
             o_rsp_data, o_rsp_valid, o_err_underflow
`ifdef FRONTEND_ARB_PERF_CNT_EN
      , input o_grant_cnt
`endif
   );

endinterface

// File: rtl/frontend_cmd_arbiter_rd_tag_fifo.sv
// Synchronous FIFO of requester IDs for outstanding reads.
// A push and pop on an empty FIFO bypass the storage: the pushed ID is
// returned directly and the occupancy stays zero.
module rd_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             bypass;
   logic             do_write;
   logic             do_read;

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == PW'(DEPTH));
   assign empty    = (count == '0);
   assign bypass   = empty && push && pop;
   assign do_write = push && !bypass && (!full || pop);
   assign do_read  = pop && !empty;
   assign pop_data = empty ? push_data : mem[rd_ptr[AW-1:0]];

   // Advance the wrapping read/write pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PW'(1);
         if (do_read)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/frontend_cmd_arbiter.sv
// Round-robin arbiter sharing one backend command channel among NUM_REQ
// frontend requesters, with a one-entry registered output stage and a
// tag FIFO that routes read data back to the issuing requester.
// Optional feature macro: FRONTEND_ARB_PERF_CNT_EN (per-requester grant counters).
module frontend_cmd_arbiter
   import frontend_command_definition_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CMD_W   = `FRONTEND_CMD_BITS,
   parameter int DATA_W  = `DQ_BITS*8,
   parameter int MAX_RD  = 8
) (
   input logic                 clk,
   input logic                 power_on_rst_n,
   frontend_cmd_arbiter_if.slave bus
);

   localparam int TAG_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_RD) + 1;

   logic [TAG_W-1:0]   rr_ptr;
   logic [TAG_W-1:0]   grant_idx;
   logic [TAG_W-1:0]   fifo_head;
   logic [NUM_REQ-1:0] eligible;
   logic               any_eligible;
   logic               slot_free;
   logic               accept;
   logic               grant_is_read;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               underflow;
   logic [CMD_W-1:0]   grant_cmd;
   logic [DATA_W-1:0]  grant_wdata;

   logic               cmd_valid_q;
   logic [CMD_W-1:0]   cmd_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [DATA_W-1:0]  rsp_data_q;
   logic               err_q;

   assign slot_free = !cmd_valid_q || bus.i_cmd_ready;

   // A read may only compete while the tag FIFO has room, counting a same-cycle pop as room.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.i_req_valid[i] &&
                       ((op_type_e'(bus.i_req_command[i*CMD_W + CMD_W - 1]) != OP_READ) ||
                        !fifo_full || bus.i_read_data_valid);
      end
   end

   // Pick the first eligible requester at or after the round-robin pointer.
   always_comb begin
      int idx;
      idx          = 0;
      any_eligible = 1'b0;
      grant_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_eligible && eligible[idx]) begin
            any_eligible = 1'b1;
            grant_idx    = TAG_W'(idx);
         end
      end
   end

   assign grant_cmd       = bus.i_req_command[int'(grant_idx)*CMD_W +: CMD_W];
   assign grant_wdata     = bus.i_req_write_data[int'(grant_idx)*DATA_W +: DATA_W];
   assign grant_is_read   = (op_type_e'(grant_cmd[CMD_W-1]) == OP_READ);
   assign accept          = any_eligible && slot_free;
   assign bus.o_req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

   assign fifo_push = accept && grant_is_read;
   assign underflow = bus.i_read_data_valid && fifo_empty && !fifo_push;
   assign fifo_pop  = bus.i_read_data_valid && !underflow;

   rd_tag_fifo #(
      .DEPTH (MAX_RD),
      .WIDTH (TAG_W)
   ) u_rd_tag_fifo (
      .clk       (clk),
      .rst_n     (power_on_rst_n),
      .push      (fifo_push),
      .push_data (grant_idx),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   fifo_count_in_range: assert property (@(posedge clk) disable iff (!power_on_rst_n)
                                         fifo_count <= CNT_W'(MAX_RD));

   // Output stage: load on accept, otherwise hold until the backend takes the command.
   always_ff @(posedge clk or negedge power_on_rst_n) begin
      if (!power_on_rst_n) begin
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         wdata_q     <= '0;
         rr_ptr      <= '0;
      end else if (accept) begin
         cmd_valid_q <= 1'b1;
         cmd_q       <= grant_cmd;
         wdata_q     <= grant_wdata;
         rr_ptr      <= TAG_W'(rr_next(int'(grant_idx), NUM_REQ));
      end else if (bus.i_cmd_ready) begin
         cmd_valid_q <= 1'b0;
      end
   end

   // Register each returning beat toward the requester at the FIFO head; flag orphan beats.
   always_ff @(posedge clk or negedge power_on_rst_n) begin
      if (!power_on_rst_n) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= fifo_pop ? (NUM_REQ'(1) << fifo_head) : '0;
         if (fifo_pop)  rsp_data_q <= bus.i_read_data;
         if (underflow) err_q      <= 1'b1;
      end
   end

   assign bus.o_cmd_valid     = cmd_valid_q;
   assign bus.o_cmd           = cmd_q;
   assign bus.o_write_data    = wdata_q;
   assign bus.o_rsp_valid     = rsp_valid_q;
   assign bus.o_rsp_data      = rsp_data_q;
   assign bus.o_err_underflow = err_q;

`ifdef FRONTEND_ARB_PERF_CNT_EN
   logic [15:0] grant_cnt [NUM_REQ];

   // Count accepted commands per requester, saturating at all-ones.
   always_ff @(posedge clk or negedge power_on_rst_n) begin
      if (!power_on_rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (int'(grant_idx) == i) && (grant_cnt[i] != 16'hFFFF))
               grant_cnt[i] <= grant_cnt[i] + 16'd1;
         end
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      bus.o_grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) bus.o_grant_cnt[i*16 +: 16] = grant_cnt[i];
   end
`else
   // Grant counters are not built in this configuration.
`endif

endmodule
